rrd_stage: RTL and testbench
============================

Name: rrd_stage

Overview:
- Register-read stage directly downstream of the issue stage.
- Takes the four per-function-unit instruction lanes issued each cycle (mul, alu1, alu2, adr) and reads both source operands from a 64-entry physical register file.
- Register-file writes come from the four execution write-back ports.
- Registers instruction plus operands into one pipeline slot per lane for the execution stage; ROB flush kills in-flight slots.

Parameters:
- IS_INST_WIDTH, 66, width of one issued-instruction lane word.
- PRF_DEPTH, 64, number of physical registers.
- PRG_IDX_BITS, 6, physical register index width.
- DATA_WIDTH, 16, register data width.
- WB_PORTS, 4, write-back ports from execution.
- BIT_INST_VLD, 65, lane-word valid bit.
- BIT_PSRC1_VLD, 64, psrc1 valid bit.
- BIT_PSRC1_LSB, 58, LSB of 6-bit psrc1 index.
- BIT_PSRC2_VLD, 57, psrc2 valid bit.
- BIT_PSRC2_LSB, 51, LSB of 6-bit psrc2 index.
- BRN_WIDTH, 7, ROB flush signal width (valid + 6-bit index).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mul_ins_frm_is  in  IS_INST_WIDTH  mult lane from issue
- alu1_ins_frm_is  in  IS_INST_WIDTH  alu1 lane
- alu2_ins_frm_is  in  IS_INST_WIDTH  alu2 lane
- adr_ins_frm_is  in  IS_INST_WIDTH  address lane
- wb_vld_frm_exe  in  WB_PORTS  per-port write enable
- wb_prg_frm_exe  in  WB_PORTS*PRG_IDX_BITS  per-port destination index, port p at [p*6+:6]
- wb_dat_frm_exe  in  WB_PORTS*DATA_WIDTH  per-port data, port p at [p*16+:16]
- fls_frm_rob  in  BRN_WIDTH  bit 6 = flush valid
- mul_ins_to_exe, alu1_ins_to_exe, alu2_ins_to_exe, adr_ins_to_exe  out  IS_INST_WIDTH each  registered lane words
- mul_opa_to_exe … adr_opa_to_exe  out  DATA_WIDTH each  registered operand A (psrc1)
- mul_opb_to_exe … adr_opb_to_exe  out  DATA_WIDTH each  registered operand B (psrc2)

Behaviour:
- Reset (async, rst_n=0): all PRF entries = 0; all *_ins_to_exe = 0, so valid bit = 0; all operand outputs = 0.
- PRF write: on posedge clk, each port p with wb_vld[p]=1 writes wb_dat[p] to entry wb_prg[p].
  - Same index on several ports in one cycle: highest p wins.
  - Index 0 is an ordinary register.
- PRF read: combinational, 8 reads (2 per lane).
  - Source-valid bit 0 → operand forced to 0, index ignored.
- Latency: lane word accepted in cycle N appears on *_to_exe in cycle N+1 with its operands. No stalls; every lane is captured every cycle.
- Lane word with valid=0 is registered as-is; operand outputs become 0.
- Flush: fls_frm_rob[6]=1 at a posedge clears the valid bit of every output slot. Operand outputs become 0. Incoming lane words in that cycle are discarded. PRF writes in the same cycle still occur.
- Reset asserted mid-operation: outputs and PRF clear immediately, independent of clk.
- No arithmetic; indices are always in range (6 bits addresses 64 entries exactly).

Optional Feature:
- Macro RRD_WB_BYPASS_EN.
- Defined: a read whose index matches a write-back with wb_vld=1 in the same cycle returns that write-back data (highest matching port wins), so dependent instructions issued on the write-back cycle see the new value.
- Undefined: reads return the PRF contents before the clock edge. The issue stage must not wake dependents until the cycle after write-back.

Decomposition:
- Shared package rrd_pkg:
  - constants for field positions (BIT_INST_VLD, BIT_PSRC*), PRG_IDX_BITS, DATA_WIDTH, WB_PORTS, lane-order encoding (0 mul, 1 alu1, 2 alu2, 3 adr);
  - typedef for the lane word and the write-back bundle.
- One natural sub-module, prf_bank:
  - 64x16 storage with 4 write ports and 8 combinational read ports;
  - write priority and optional bypass inside it.
- rrd_stage holds field extraction, output pipeline registers and flush.

Test Plan:
- Reset then idle: after rst_n release, all *_to_exe = 0; no output valid for 10 cycles with zero inputs.
- Write then read: wb port0 writes preg 5 = 0x1234 in cycle 1; cycle 2 alu1 lane psrc1=5 (valid), psrc2 invalid → cycle 3 alu1_opa=0x1234, alu1_opb=0, valid=1.
- Write conflict: cycle 1 ports 0 and 3 both write preg 9 (0xAAAA, 0x5555); later read of preg 9 → 0x5555.
- Bypass: same cycle wb port2 writes preg 12 = 0x00FF and mul lane reads psrc2=12 (old value 0).
  - With RRD_WB_BYPASS_EN: mul_opb = 0x00FF next cycle.
  - Without it: mul_opb = 0.
- Flush: all four lanes valid in cycle 4 with fls_frm_rob=7'b1000011 → cycle 5 all output valid bits 0; a wb in cycle 4 to preg 3 = 0x0042 is still readable as 0x0042 afterwards.
- Async reset mid-stream: drop rst_n between edges while lanes are valid → outputs 0 immediately; PRF reads return 0 after release.

Source files
------------

// File: rtl/rrd_pkg.sv
// Shared constants and types for the register-read stage: lane-word field
// positions, register-file geometry, lane ordering and the write-back bundle.
package rrd_pkg;

  localparam int IS_INST_WIDTH = 66;
  localparam int PRF_DEPTH     = 64;
  localparam int PRG_IDX_BITS  = 6;
  localparam int DATA_WIDTH    = 16;
  localparam int WB_PORTS      = 4;
  localparam int BIT_INST_VLD  = 65;
  localparam int BIT_PSRC1_VLD = 64;
  localparam int BIT_PSRC1_LSB = 58;
  localparam int BIT_PSRC2_VLD = 57;
  localparam int BIT_PSRC2_LSB = 51;
  localparam int BRN_WIDTH     = 7;
  localparam int BIT_FLS_VLD   = BRN_WIDTH - 1;
  localparam int NUM_LANES     = 4;
  localparam int RD_PORTS      = 2 * NUM_LANES;

  localparam logic [1:0] LANE_MUL  = 2'd0;
  localparam logic [1:0] LANE_ALU1 = 2'd1;
  localparam logic [1:0] LANE_ALU2 = 2'd2;
  localparam logic [1:0] LANE_ADR  = 2'd3;

  typedef logic [IS_INST_WIDTH-1:0] lane_word_t;
  typedef logic [PRG_IDX_BITS-1:0]  prg_idx_t;
  typedef logic [DATA_WIDTH-1:0]    data_t;

  typedef struct packed {
    logic [WB_PORTS-1:0]              vld;
    logic [WB_PORTS*PRG_IDX_BITS-1:0] prg;
    logic [WB_PORTS*DATA_WIDTH-1:0]   dat;
  } wb_bundle_t;

endpackage

// File: rtl/rrd_stage_if.sv
// Issue/write-back/flush inputs and execution-side outputs of the register-read
// stage; master drives the inputs, slave is the stage itself.
interface rrd_stage_if
  import rrd_pkg::*;
();

  lane_word_t                        mul_ins_frm_is;
  lane_word_t                        alu1_ins_frm_is;
  lane_word_t                        alu2_ins_frm_is;
  lane_word_t                        adr_ins_frm_is;
  logic [WB_PORTS-1:0]               wb_vld_frm_exe;
  logic [WB_PORTS*PRG_IDX_BITS-1:0]  wb_prg_frm_exe;
  logic [WB_PORTS*DATA_WIDTH-1:0]    wb_dat_frm_exe;
  logic [BRN_WIDTH-1:0]              fls_frm_rob;
  lane_word_t                        mul_ins_to_exe;
  lane_word_t                        alu1_ins_to_exe;
  lane_word_t                        alu2_ins_to_exe;
  lane_word_t                        adr_ins_to_exe;
  data_t                             mul_opa_to_exe;
  data_t                             alu1_opa_to_exe;
  data_t                             alu2_opa_to_exe;
  data_t                             adr_opa_to_exe;
  data_t                             mul_opb_to_exe;
  data_t                             alu1_opb_to_exe;
  data_t                             alu2_opb_to_exe;
  data_t                             adr_opb_to_exe;

  modport master (
    output mul_ins_frm_is, alu1_ins_frm_is, alu2_ins_frm_is, adr_ins_frm_is,
    output wb_vld_frm_exe, wb_prg_frm_exe, wb_dat_frm_exe, fls_frm_rob,
    input  mul_ins_to_exe, alu1_ins_to_exe, alu2_ins_to_exe, adr_ins_to_exe,
    input  mul_opa_to_exe, alu1_opa_to_exe, alu2_opa_to_exe, adr_opa_to_exe,
    input  mul_opb_to_exe, alu1_opb_to_exe, alu2_opb_to_exe, adr_opb_to_exe
  );

  modport slave (
    input  mul_ins_frm_is, alu1_ins_frm_is, alu2_ins_frm_is, adr_ins_frm_is,
    input  wb_vld_frm_exe, wb_prg_frm_exe, wb_dat_frm_exe, fls_frm_rob,
    output mul_ins_to_exe, alu1_ins_to_exe, alu2_ins_to_exe, adr_ins_to_exe,
    output mul_opa_to_exe, alu1_opa_to_exe, alu2_opa_to_exe, adr_opa_to_exe,
    output mul_opb_to_exe, alu1_opb_to_exe, alu2_opb_to_exe, adr_opb_to_exe
  );

endinterface

// File: rtl/rrd_stage_prf_bank.sv
// 64x16 physical register file: 4 prioritised write ports, 8 combinational reads.
// RRD_WB_BYPASS_EN forwards same-cycle write-back data to matching reads.
module prf_bank
  import rrd_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  wb_bundle_t                             wb_i,
  input  logic [RD_PORTS-1:0][PRG_IDX_BITS-1:0]  rd_idx_i,
  output logic [RD_PORTS-1:0][DATA_WIDTH-1:0]    rd_dat_o
);

  logic [PRF_DEPTH-1:0][DATA_WIDTH-1:0] mem_d;
  logic [PRF_DEPTH-1:0][DATA_WIDTH-1:0] mem_q;

  // Later ports overwrite earlier ones, so the highest port wins a shared index.
  always_comb begin
    mem_d = mem_q;
    for (int e = 0; e < PRF_DEPTH; e++) begin
      for (int p = 0; p < WB_PORTS; p++) begin
        mem_d[e] = (wb_i.vld[p] &&
                    (wb_i.prg[p*PRG_IDX_BITS +: PRG_IDX_BITS] == PRG_IDX_BITS'(e)))
                   ? wb_i.dat[p*DATA_WIDTH +: DATA_WIDTH] : mem_d[e];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    for (int r = 0; r < RD_PORTS; r++) begin
      rd_dat_o[r] = mem_q[rd_idx_i[r]];
`ifdef RRD_WB_BYPASS_EN
      for (int p = 0; p < WB_PORTS; p++) begin
        rd_dat_o[r] = (wb_i.vld[p] &&
                       (wb_i.prg[p*PRG_IDX_BITS +: PRG_IDX_BITS] == rd_idx_i[r]))
                      ? wb_i.dat[p*DATA_WIDTH +: DATA_WIDTH] : rd_dat_o[r];
      end
`else
      rd_dat_o[r] = rd_dat_o[r];
`endif
    end
  end

endmodule

// File: rtl/rrd_stage.sv
// Register-read stage: reads both sources of the four issued lanes from the PRF
// and registers lane word plus operands for execute. Option: RRD_WB_BYPASS_EN.
module rrd_stage
  import rrd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  rrd_stage_if.slave  bus
);

  logic [NUM_LANES-1:0][IS_INST_WIDTH-1:0] lane_in_s;
  logic [RD_PORTS-1:0][PRG_IDX_BITS-1:0]   rd_idx_s;
  logic [RD_PORTS-1:0][DATA_WIDTH-1:0]     rd_dat_s;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]    opa_s, opb_s;
  logic [NUM_LANES-1:0][IS_INST_WIDTH-1:0] ins_d, ins_q;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]    opa_d, opa_q, opb_d, opb_q;
  wb_bundle_t                              wb_s;
  logic                                    flush_s;
  logic                                    fls_idx_unused_s;

  assign lane_in_s[LANE_MUL]  = bus.mul_ins_frm_is;
  assign lane_in_s[LANE_ALU1] = bus.alu1_ins_frm_is;
  assign lane_in_s[LANE_ALU2] = bus.alu2_ins_frm_is;
  assign lane_in_s[LANE_ADR]  = bus.adr_ins_frm_is;

  assign wb_s.vld = bus.wb_vld_frm_exe;
  assign wb_s.prg = bus.wb_prg_frm_exe;
  assign wb_s.dat = bus.wb_dat_frm_exe;

  assign flush_s          = bus.fls_frm_rob[BIT_FLS_VLD];
  assign fls_idx_unused_s = ^bus.fls_frm_rob[BIT_FLS_VLD-1:0];

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      rd_idx_s[2*l]   = lane_in_s[l][BIT_PSRC1_LSB +: PRG_IDX_BITS];
      rd_idx_s[2*l+1] = lane_in_s[l][BIT_PSRC2_LSB +: PRG_IDX_BITS];
    end
  end

  prf_bank u_prf_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_i     (wb_s),
    .rd_idx_i (rd_idx_s),
    .rd_dat_o (rd_dat_s)
  );

  // Operands are zero unless both the lane and the individual source are valid.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      opa_s[l] = (lane_in_s[l][BIT_INST_VLD] && lane_in_s[l][BIT_PSRC1_VLD])
                 ? rd_dat_s[2*l] : {DATA_WIDTH{1'b0}};
      opb_s[l] = (lane_in_s[l][BIT_INST_VLD] && lane_in_s[l][BIT_PSRC2_VLD])
                 ? rd_dat_s[2*l+1] : {DATA_WIDTH{1'b0}};
    end
  end

  // A flush drops the incoming lanes and invalidates what is already held.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      ins_d[l] = lane_in_s[l];
      opa_d[l] = {DATA_WIDTH{1'b0}};
      opb_d[l] = {DATA_WIDTH{1'b0}};
      if (flush_s) begin
        ins_d[l]               = ins_q[l];
        ins_d[l][BIT_INST_VLD] = 1'b0;
      end else begin
        opa_d[l] = opa_s[l];
        opb_d[l] = opb_s[l];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
    end else begin
      ins_q <= ins_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
    end
  end

  assign bus.mul_ins_to_exe  = ins_q[LANE_MUL];
  assign bus.alu1_ins_to_exe = ins_q[LANE_ALU1];
  assign bus.alu2_ins_to_exe = ins_q[LANE_ALU2];
  assign bus.adr_ins_to_exe  = ins_q[LANE_ADR];
  assign bus.mul_opa_to_exe  = opa_q[LANE_MUL];
  assign bus.alu1_opa_to_exe = opa_q[LANE_ALU1];
  assign bus.alu2_opa_to_exe = opa_q[LANE_ALU2];
  assign bus.adr_opa_to_exe  = opa_q[LANE_ADR];
  assign bus.mul_opb_to_exe  = opb_q[LANE_MUL];
  assign bus.alu1_opb_to_exe = opb_q[LANE_ALU1];
  assign bus.alu2_opb_to_exe = opb_q[LANE_ALU2];
  assign bus.adr_opb_to_exe  = opb_q[LANE_ADR];

endmodule

// File: tb/tb_rrd_stage.sv
// Scoreboard bench for rrd_stage: a reference PRF model predicts each cycle's
// lane outputs, queued at drive time and compared one cycle later.
module tb_rrd_stage;
  import rrd_pkg::*;

  typedef struct {
    logic [65:0] ins;
    logic [15:0] opa;
    logic [15:0] opb;
  } exp_t;

  logic clk;
  logic rst_n;
  rrd_stage_if bus ();

  rrd_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  logic [15:0] mem[64];
  logic [65:0] prev[4];
  logic [65:0] ln[4];
  logic [3:0]  wv;
  logic [5:0]  wp[4];
  logic [15:0] wd[4];
  logic [6:0]  fls;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [65:0] mk(input logic v, input logic s1v, input logic [5:0] s1,
                                     input logic s2v, input logic [5:0] s2);
    logic [65:0] w;
    w = {2'b00, $urandom(), $urandom()};
    w[65] = v;
    w[64] = s1v;
    w[63:58] = s1;
    w[57] = s2v;
    w[56:51] = s2;
    return w;
  endfunction

  function automatic logic [15:0] rd_model(input logic [5:0] idx);
    logic [15:0] v;
    v = mem[idx];
`ifdef RRD_WB_BYPASS_EN
    for (int p = 0; p < 4; p++)
      if (wv[p] && wp[p] == idx) v = wd[p];
`endif
    return v;
  endfunction

  task automatic get_out(input int l, output logic [65:0] ins, output logic [15:0] a,
                         output logic [15:0] b);
    case (l)
      0: begin ins = bus.mul_ins_to_exe;  a = bus.mul_opa_to_exe;  b = bus.mul_opb_to_exe;  end
      1: begin ins = bus.alu1_ins_to_exe; a = bus.alu1_opa_to_exe; b = bus.alu1_opb_to_exe; end
      2: begin ins = bus.alu2_ins_to_exe; a = bus.alu2_opa_to_exe; b = bus.alu2_opb_to_exe; end
      default: begin ins = bus.adr_ins_to_exe; a = bus.adr_opa_to_exe; b = bus.adr_opb_to_exe; end
    endcase
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 4; i++) begin
      ln[i] = '0;
      wp[i] = '0;
      wd[i] = '0;
    end
    wv  = '0;
    fls = '0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) prev[i] = '0;
  endtask

  task automatic check_all_zero(input string tag);
    logic [65:0] ins;
    logic [15:0] a, b;
    for (int l = 0; l < 4; l++) begin
      get_out(l, ins, a, b);
      chk($sformatf("%s_L%0d_ins", tag, l), ins, 66'd0);
      chk($sformatf("%s_L%0d_opa", tag, l), {50'd0, a}, 66'd0);
      chk($sformatf("%s_L%0d_opb", tag, l), {50'd0, b}, 66'd0);
    end
  endtask

  task automatic cycle(input string tag);
    exp_t        e;
    logic [65:0] ins;
    logic [15:0] a, b;
    bus.mul_ins_frm_is  = ln[0];
    bus.alu1_ins_frm_is = ln[1];
    bus.alu2_ins_frm_is = ln[2];
    bus.adr_ins_frm_is  = ln[3];
    bus.wb_vld_frm_exe  = wv;
    bus.wb_prg_frm_exe  = {wp[3], wp[2], wp[1], wp[0]};
    bus.wb_dat_frm_exe  = {wd[3], wd[2], wd[1], wd[0]};
    bus.fls_frm_rob     = fls;
    for (int l = 0; l < 4; l++) begin
      if (fls[6]) begin
        e.ins = prev[l];
        e.ins[65] = 1'b0;
        e.opa = '0;
        e.opb = '0;
      end else begin
        e.ins = ln[l];
        e.opa = (ln[l][65] && ln[l][64]) ? rd_model(ln[l][63:58]) : 16'd0;
        e.opb = (ln[l][65] && ln[l][57]) ? rd_model(ln[l][56:51]) : 16'd0;
      end
      prev[l] = e.ins;
      sb.push_back(e);
    end
    for (int p = 0; p < 4; p++)
      if (wv[p]) mem[wp[p]] = wd[p];
    @(posedge clk);
    #1;
    for (int l = 0; l < 4; l++) begin
      if (sb.size() == 0) begin
        chk($sformatf("%s_sb_underflow", tag), 66'd0, 66'd1);
      end else begin
        e = sb.pop_front();
        get_out(l, ins, a, b);
        chk($sformatf("%s_L%0d_ins", tag, l), ins, e.ins);
        chk($sformatf("%s_L%0d_opa", tag, l), {50'd0, a}, {50'd0, e.opa});
        chk($sformatf("%s_L%0d_opb", tag, l), {50'd0, b}, {50'd0, e.opb});
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    clear_model();
    bus.mul_ins_frm_is  = '0;
    bus.alu1_ins_frm_is = '0;
    bus.alu2_ins_frm_is = '0;
    bus.adr_ins_frm_is  = '0;
    bus.wb_vld_frm_exe  = '0;
    bus.wb_prg_frm_exe  = '0;
    bus.wb_dat_frm_exe  = '0;
    bus.fls_frm_rob     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all_zero("reset");
    for (int i = 0; i < 10; i++) cycle("idle");

    // write preg5, then read it on alu1 with psrc2 invalid
    wv[0] = 1'b1; wp[0] = 6'd5; wd[0] = 16'h1234;
    cycle("wr5");
    idle_inputs();
    ln[1] = mk(1'b1, 1'b1, 6'd5, 1'b0, 6'd5);
    cycle("rd5");
    chk("rd5_alu1_opa", {50'd0, bus.alu1_opa_to_exe}, {50'd0, 16'h1234});
    chk("rd5_alu1_opb", {50'd0, bus.alu1_opb_to_exe}, 66'd0);
    chk("rd5_alu1_vld", {65'd0, bus.alu1_ins_to_exe[65]}, 66'd1);

    // write conflicts: 0 vs 3 on preg9, 1 vs 2 on preg20
    idle_inputs();
    wv = 4'b1111;
    wp[0] = 6'd9;  wd[0] = 16'hAAAA;
    wp[1] = 6'd20; wd[1] = 16'h1111;
    wp[2] = 6'd20; wd[2] = 16'h2222;
    wp[3] = 6'd9;  wd[3] = 16'h5555;
    cycle("conflict_wr");
    idle_inputs();
    ln[0] = mk(1'b1, 1'b1, 6'd9, 1'b1, 6'd20);
    ln[3] = mk(1'b1, 1'b0, 6'd0, 1'b1, 6'd9);
    ln[2] = mk(1'b0, 1'b1, 6'd9, 1'b1, 6'd9);
    cycle("conflict_rd");
    chk("conflict_mul_opa", {50'd0, bus.mul_opa_to_exe}, {50'd0, 16'h5555});
    chk("conflict_mul_opb", {50'd0, bus.mul_opb_to_exe}, {50'd0, 16'h2222});

    // same-cycle write-back and read of preg12
    idle_inputs();
    wv[2] = 1'b1; wp[2] = 6'd12; wd[2] = 16'h00FF;
    ln[0] = mk(1'b1, 1'b0, 6'd0, 1'b1, 6'd12);
    cycle("bypass");
`ifdef RRD_WB_BYPASS_EN
    chk("bypass_mul_opb", {50'd0, bus.mul_opb_to_exe}, {50'd0, 16'h00FF});
`else
    chk("bypass_mul_opb", {50'd0, bus.mul_opb_to_exe}, 66'd0);
`endif

    // flush with all lanes valid and a concurrent write-back
    idle_inputs();
    ln[0] = mk(1'b1, 1'b1, 6'd0, 1'b0, 6'd0);
    ln[1] = mk(1'b1, 1'b1, 6'd0, 1'b0, 6'd0);
    ln[2] = mk(1'b1, 1'b1, 6'd0, 1'b0, 6'd0);
    ln[3] = mk(1'b1, 1'b1, 6'd0, 1'b0, 6'd0);
    cycle("pre_flush");
    ln[0] = mk(1'b1, 1'b1, 6'd5, 1'b1, 6'd9);
    ln[1] = mk(1'b1, 1'b1, 6'd5, 1'b1, 6'd9);
    ln[2] = mk(1'b1, 1'b1, 6'd5, 1'b1, 6'd9);
    ln[3] = mk(1'b1, 1'b1, 6'd5, 1'b1, 6'd9);
    fls = 7'b1000011;
    wv[1] = 1'b1; wp[1] = 6'd3; wd[1] = 16'h0042;
    cycle("flush");
    chk("flush_adr_vld", {65'd0, bus.adr_ins_to_exe[65]}, 66'd0);
    idle_inputs();
    ln[2] = mk(1'b1, 1'b1, 6'd3, 1'b1, 6'd3);
    cycle("after_flush");
    chk("after_flush_alu2_opa", {50'd0, bus.alu2_opa_to_exe}, {50'd0, 16'h0042});

    // random traffic
    for (int i = 0; i < 40; i++) begin
      for (int l = 0; l < 4; l++)
        ln[l] = mk(1'($urandom_range(0, 3) != 0), 1'($urandom()), 6'($urandom_range(0, 15)),
                   1'($urandom()), 6'($urandom_range(0, 15)));
      wv = 4'($urandom());
      for (int p = 0; p < 4; p++) begin
        wp[p] = 6'($urandom_range(0, 15));
        wd[p] = 16'($urandom());
      end
      fls = ($urandom_range(0, 7) == 0) ? {1'b1, 6'($urandom())} : {1'b0, 6'($urandom())};
      cycle("rand");
    end

    // asynchronous reset between edges while lanes are valid
    idle_inputs();
    for (int l = 0; l < 4; l++) ln[l] = mk(1'b1, 1'b1, 6'd5, 1'b1, 6'd9);
    cycle("pre_arst");
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("arst");
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    sb.delete();
    idle_inputs();
    ln[0] = mk(1'b1, 1'b1, 6'd5, 1'b1, 6'd9);
    ln[1] = mk(1'b1, 1'b1, 6'd3, 1'b1, 6'd12);
    ln[2] = mk(1'b1, 1'b1, 6'd20, 1'b1, 6'd0);
    cycle("post_arst");
    chk("post_arst_mul_opa", {50'd0, bus.mul_opa_to_exe}, 66'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
